// File: rtl/sd_pkg.sv
// sd_pkg: definitions shared by the SD block buffer and its buffer RAM.
//   sd_state_t  - transfer FSM states
//   BLOCK_BYTES - bytes per SD block (buffer depth)
//   OP_READ/OP_WRITE - op codes presented to the SD card controller
//   tx_index()  - maps the 10-bit transfer count onto a buffer index
package sd_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_BUSY,
    XFER,
    DONE,
    ERR
  } sd_state_t;

  localparam int unsigned BLOCK_BYTES = 512;
  localparam int unsigned ADDR_W      = 9;
  localparam int unsigned CNT_W       = 10;

  localparam logic [CNT_W-1:0] COUNT_FULL = CNT_W'(BLOCK_BYTES);

  localparam logic OP_READ  = 1'b0;
  localparam logic OP_WRITE = 1'b1;

  // Once the count has saturated at a full block, keep presenting the last
  // byte rather than wrapping back to index 0.
  function automatic logic [ADDR_W-1:0] tx_index(input logic [CNT_W-1:0] count);
    if (count >= COUNT_FULL) begin
      return ADDR_W'(BLOCK_BYTES - 1);
    end
    return count[ADDR_W-1:0];
  endfunction

endpackage

// File: rtl/sd_buf_ram.sv
// sd_buf_ram: 512 x 8 block buffer.
//   clk, rst_n          - clock and async active-low reset (read register only)
//   wr_en/wr_addr/wr_data - single write port (port A)
//   rd_addr/rd_data     - user read port, registered, one-cycle latency
//   peek_addr/peek_data - asynchronous read used to feed card writes
// Memory contents are never cleared by reset.
module sd_buf_ram
  import sd_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [7:0]        wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [7:0]        rd_data,
  input  logic [ADDR_W-1:0] peek_addr,
  output logic [7:0]        peek_data
);

  logic [7:0] mem [BLOCK_BYTES];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data <= 8'h00;
    end else begin
      rd_data <= mem[rd_addr];
    end
  end

  assign peek_data = mem[peek_addr];

endmodule

// File: rtl/sd_block_buffer.sv
// sd_block_buffer: 512-byte block buffer between a user port and an SD card
// controller. A request moves one block card->buffer (read) or buffer->card
// (write).
//   clk, rst_n                - clock, async active-low reset
//   req_valid/req_write/req_addr/req_ready - block request handshake
//   buf_wr_en/buf_wr_addr/buf_wr_data      - user buffer writes (IDLE only)
//   buf_rd_addr/buf_rd_data   - user buffer reads, one-cycle latency
//   done, error               - end-of-transfer pulse, sticky error
//   sd_*                      - SD card controller interface
// Optional feature: define SD_BUF_TIMEOUT_EN to enable a transfer watchdog
// that aborts to ERR after TIMEOUT_CYCLES in ISSUE/WAIT_BUSY/XFER.
//
// state     | meaning
// ----------+---------------------------------------------------------
// IDLE      | ready for a request; user may write the buffer
// ISSUE     | sd_execute held high until the controller reports busy
// WAIT_BUSY | one-cycle settle after busy is seen
// XFER      | moving bytes; count tracks position in the block
// DONE      | one-cycle done pulse, clean completion
// ERR       | one-cycle done pulse with error set
module sd_block_buffer
  import sd_pkg::*;
#(
  parameter logic [23:0] TIMEOUT_CYCLES = 24'd5_000_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  output logic        req_ready,
  input  logic        buf_wr_en,
  input  logic [8:0]  buf_wr_addr,
  input  logic [7:0]  buf_wr_data,
  input  logic [8:0]  buf_rd_addr,
  output logic [7:0]  buf_rd_data,
  output logic        done,
  output logic        error,
  output logic        sd_execute,
  output logic        sd_op_code,
  output logic [31:0] sd_block_address,
  output logic [7:0]  sd_outgoing_byte,
  input  logic [7:0]  sd_incoming_byte,
  input  logic        sd_finished_byte,
  input  logic        sd_finished_block,
  input  logic        sd_busy
);

  sd_state_t         state;
  logic [CNT_W-1:0]  count;
  logic [CNT_W-1:0]  count_next;
  logic              byte_ok;
  logic              user_we;
  logic              xfer_we;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_waddr;
  logic [7:0]        ram_wdata;
  logic [7:0]        peek_data;
  logic              wd_expired;

  // A byte only advances the count while room remains; the 513th and later
  // bytes are dropped so they can never wrap onto buffer[0].
  assign byte_ok    = sd_finished_byte && (count < COUNT_FULL);
  assign count_next = byte_ok ? (count + 10'd1) : count;

  assign user_we   = (state == IDLE) && buf_wr_en;
  assign xfer_we   = (state == XFER) && (sd_op_code == OP_READ) && byte_ok;
  assign ram_we    = user_we || xfer_we;
  assign ram_waddr = xfer_we ? count[ADDR_W-1:0] : buf_wr_addr;
  assign ram_wdata = xfer_we ? sd_incoming_byte : buf_wr_data;

  assign sd_outgoing_byte = ((state != IDLE) && (sd_op_code == OP_WRITE)) ? peek_data : 8'h00;

  sd_buf_ram u_ram (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en     (ram_we),
    .wr_addr   (ram_waddr),
    .wr_data   (ram_wdata),
    .rd_addr   (buf_rd_addr),
    .rd_data   (buf_rd_data),
    .peek_addr (tx_index(count)),
    .peek_data (peek_data)
  );

`ifdef SD_BUF_TIMEOUT_EN
  // Down-counter reloaded while idle; terminal count zero aborts the transfer.
  logic [23:0] wd_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_count <= 24'd0;
    end else if (state == IDLE) begin
      wd_count <= TIMEOUT_CYCLES - 24'd1;
    end else if (wd_count != 24'd0) begin
      wd_count <= wd_count - 24'd1;
    end
  end

  assign wd_expired = (wd_count == 24'd0) &&
                      ((state == ISSUE) || (state == WAIT_BUSY) || (state == XFER));
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
  assign wd_expired     = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= IDLE;
      count            <= '0;
      req_ready        <= 1'b0;
      sd_execute       <= 1'b0;
      sd_op_code       <= OP_READ;
      sd_block_address <= 32'h0;
      done             <= 1'b0;
      error            <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          req_ready <= 1'b1;
          if (req_valid && req_ready) begin
            sd_op_code       <= req_write;
            sd_block_address <= req_addr;
            error            <= 1'b0;
            count            <= '0;
            sd_execute       <= 1'b1;
            req_ready        <= 1'b0;
            state            <= ISSUE;
          end
        end

        ISSUE: begin
          if (wd_expired) begin
            sd_execute <= 1'b0;
            error      <= 1'b1;
            done       <= 1'b1;
            state      <= ERR;
          end else if (sd_busy) begin
            sd_execute <= 1'b0;
            state      <= WAIT_BUSY;
          end
        end

        WAIT_BUSY: begin
          if (wd_expired) begin
            error <= 1'b1;
            done  <= 1'b1;
            state <= ERR;
          end else begin
            state <= XFER;
          end
        end

        XFER: begin
          count <= count_next;
          if (sd_finished_byte && !byte_ok && (sd_op_code == OP_READ)) begin
            error <= 1'b1;
          end
          // Same-cycle byte and block end: judge completeness on count_next.
          if (sd_finished_block) begin
            done <= 1'b1;
            if (count_next == COUNT_FULL) begin
              state <= DONE;
            end else begin
              error <= 1'b1;
              state <= ERR;
            end
          end else if (wd_expired) begin
            error <= 1'b1;
            done  <= 1'b1;
            state <= ERR;
          end
        end

        DONE: begin
          req_ready <= 1'b1;
          state     <= IDLE;
        end

        ERR: begin
          error     <= 1'b1;
          req_ready <= 1'b1;
          state     <= IDLE;
        end

        default: begin
          sd_execute <= 1'b0;
          req_ready  <= 1'b0;
          state      <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sd_block_buffer.sv
module tb_sd_block_buffer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_write = 1'b0;
  logic [31:0] req_addr = 32'h0;
  logic        req_ready;
  logic        buf_wr_en = 1'b0;
  logic [8:0]  buf_wr_addr = 9'h0;
  logic [7:0]  buf_wr_data = 8'h0;
  logic [8:0]  buf_rd_addr = 9'h0;
  logic [7:0]  buf_rd_data;
  logic        done;
  logic        error;
  logic        sd_execute;
  logic        sd_op_code;
  logic [31:0] sd_block_address;
  logic [7:0]  sd_outgoing_byte;
  logic [7:0]  sd_incoming_byte = 8'h0;
  logic        sd_finished_byte = 1'b0;
  logic        sd_finished_block = 1'b0;
  logic        sd_busy = 1'b0;

  int checks = 0;
  int failures = 0;

  logic [7:0] model_mem [512];
  logic [7:0] wr_q [$];
  logic [7:0] rd_q [$];

  always #5 clk = ~clk;

  sd_block_buffer #(.TIMEOUT_CYCLES(24'd100)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .req_valid         (req_valid),
    .req_write         (req_write),
    .req_addr          (req_addr),
    .req_ready         (req_ready),
    .buf_wr_en         (buf_wr_en),
    .buf_wr_addr       (buf_wr_addr),
    .buf_wr_data       (buf_wr_data),
    .buf_rd_addr       (buf_rd_addr),
    .buf_rd_data       (buf_rd_data),
    .done              (done),
    .error             (error),
    .sd_execute        (sd_execute),
    .sd_op_code        (sd_op_code),
    .sd_block_address  (sd_block_address),
    .sd_outgoing_byte  (sd_outgoing_byte),
    .sd_incoming_byte  (sd_incoming_byte),
    .sd_finished_byte  (sd_finished_byte),
    .sd_finished_block (sd_finished_block),
    .sd_busy           (sd_busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s obs=0x%0h exp=0x%0h t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_exec"},  sd_execute, 0);
    chk({tag, "_op"},    sd_op_code, 0);
    chk({tag, "_baddr"}, sd_block_address, 0);
    chk({tag, "_done"},  done, 0);
    chk({tag, "_err"},   error, 0);
    chk({tag, "_ready"}, req_ready, 0);
    chk({tag, "_out"},   sd_outgoing_byte, 0);
    chk({tag, "_rd"},    buf_rd_data, 0);
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("ready_at_release", req_ready, 0);
    @(negedge clk);
    chk("ready_after_release", req_ready, 1);
  endtask

  task automatic start_req(input logic wr, input logic [31:0] addr);
    int n = 0;
    @(negedge clk);
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("req_ready_wait", req_ready, 1);
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = addr;
    @(negedge clk);
    req_valid = 1'b0;
    req_write = 1'b0;
    req_addr  = 32'h0;
    chk("exec_rise", sd_execute, 1);
    chk("op_code", sd_op_code, wr);
    chk("block_addr", sd_block_address, addr);
    chk("err_cleared", error, 0);
    chk("ready_low", req_ready, 0);
    @(negedge clk);
    chk("exec_hold", sd_execute, 1);
    sd_busy = 1'b1;
    @(negedge clk);
    chk("exec_fall", sd_execute, 0);
  endtask

  // kind 0: i[7:0]; 1: 0x55; 2: 0x80^i then 0xEE past a block; else 0x40+i
  task automatic send_read(input int n, input int kind, input bit merge_last);
    for (int i = 0; i < n; i++) begin
      logic [7:0] v;
      case (kind)
        0:       v = 8'(i);
        1:       v = 8'h55;
        2:       v = (i < 512) ? (8'h80 ^ 8'(i)) : 8'hEE;
        default: v = 8'h40 + 8'(i);
      endcase
      if (i < 512) model_mem[i] = v;
      @(negedge clk);
      sd_finished_byte = 1'b1;
      sd_incoming_byte = v;
      if (merge_last && i == n - 1) begin
        sd_finished_block = 1'b1;
      end else begin
        @(negedge clk);
        sd_finished_byte = 1'b0;
      end
    end
  endtask

  task automatic send_write(input int n);
    for (int i = 0; i < n; i++) begin
      logic [7:0] exp;
      @(negedge clk);
      exp = wr_q.pop_front();
      chk($sformatf("wr_byte%0d", i), sd_outgoing_byte, exp);
      if (i == 100) begin
        buf_wr_en   = 1'b1;
        buf_wr_addr = 9'd5;
        buf_wr_data = 8'hAA;
      end
      sd_finished_byte = 1'b1;
      @(negedge clk);
      sd_finished_byte = 1'b0;
      buf_wr_en = 1'b0;
    end
  endtask

  task automatic finish_block(input bit merged, input logic exp_err);
    int seen = 0;
    if (!merged) begin
      @(negedge clk);
      sd_finished_block = 1'b1;
    end
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (k == 0) begin
        sd_finished_block = 1'b0;
        sd_finished_byte  = 1'b0;
        sd_busy           = 1'b0;
      end
      if (done) seen++;
    end
    chk("done_once", seen, 1);
    chk("error_flag", error, exp_err);
    chk("ready_back", req_ready, 1);
  endtask

  task automatic read_buf(input int a);
    @(negedge clk);
    buf_rd_addr = 9'(a);
    rd_q.push_back(model_mem[a]);
    @(negedge clk);
    chk($sformatf("rd_buf%0d", a), buf_rd_data, rd_q.pop_front());
  endtask

  initial begin
    #1ms;
    $display("FAIL global_timeout");
    $fatal(1, "simulation did not finish");
  end

  initial begin
    int seen;
    repeat (3) @(negedge clk);
    chk_outputs_zero("reset");
    release_reset();

    // Read block 0x10, last byte coincident with block end.
    start_req(1'b0, 32'h10);
    send_read(512, 0, 1'b1);
    finish_block(1'b1, 1'b0);
    read_buf(300);
    chk("rd300_const", model_mem[300], 8'h2C);
    read_buf(0);
    read_buf(511);

    // Write: preload ~i, controller pulls bytes back out.
    for (int i = 0; i < 512; i++) begin
      @(negedge clk);
      buf_wr_en   = 1'b1;
      buf_wr_addr = 9'(i);
      buf_wr_data = ~8'(i);
      model_mem[i] = ~8'(i);
      wr_q.push_back(~8'(i));
    end
    @(negedge clk);
    buf_wr_en = 1'b0;
    start_req(1'b1, 32'hABCD_0001);
    send_write(512);
    finish_block(1'b0, 1'b0);
    read_buf(5);
    read_buf(300);

    // Short block: 511 bytes then block end.
    start_req(1'b0, 32'h30);
    send_read(511, 1, 1'b0);
    finish_block(1'b0, 1'b1);

    // Overlong block: 513th byte dropped.
    start_req(1'b0, 32'h40);
    send_read(513, 2, 1'b0);
    chk("drop_err", error, 1);
    finish_block(1'b0, 1'b1);
    read_buf(0);
    read_buf(511);

    // Reset in the middle of a read.
    start_req(1'b0, 32'h20);
    send_read(200, 3, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    sd_busy = 1'b0;
    #1;
    chk_outputs_zero("midrst");
    seen = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (done) seen++;
    end
    chk("midrst_no_done", seen, 0);
    release_reset();
    read_buf(50);
    read_buf(300);

`ifdef SD_BUF_TIMEOUT_EN
    begin
      int n = 0;
      @(negedge clk);
      req_valid = 1'b1;
      req_write = 1'b0;
      req_addr  = 32'h77;
      @(negedge clk);
      req_valid = 1'b0;
      chk("wd_exec", sd_execute, 1);
      while (!done && n < 200) begin
        @(negedge clk);
        n++;
      end
      chk("wd_cycles", n, 100);
      chk("wd_error", error, 1);
      @(negedge clk);
      chk("wd_ready", req_ready, 1);
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sd_block_buffer.md
SD_BLOCK_BUFFER -- requirements
Module: sd_block_buffer

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 24'd5_000_000; cycles allowed per block transfer before abort (used only with SD_BUF_TIMEOUT_EN).
REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk  in  1  master clock; one clock, all logic on rising edge.
- rst_n  in  1  reset; asynchronous assert, active-low.
- req_valid  in  1  user block request.
- req_write  in  1  1 = write buffer to card, 0 = read card into buffer.
- req_addr  in  32  card block address.
- req_ready  out  1  high in IDLE only.
- buf_wr_en  in  1  user buffer write strobe.
- buf_wr_addr  in  9  user buffer write index.
- buf_wr_data  in  8  user buffer write byte.
- buf_rd_addr  in  9  user buffer read index.
- buf_rd_data  out  8  user buffer read byte, one-cycle latency.
- done  out  1  one-cycle pulse at transfer end.
- error  out  1  sticky error flag; cleared on next accepted request.
- sd_execute  out  1  start strobe to the SD card controller.
- sd_op_code  out  1  operation code to controller; 0 = READ, 1 = WRITE.
- sd_block_address  out  32  block address to controller.
- sd_outgoing_byte  out  8  byte supplied to controller on writes.
- sd_incoming_byte  in  8  byte received from controller on reads.
- sd_finished_byte  in  1  one-cycle pulse per byte moved.
- sd_finished_block  in  1  one-cycle pulse at block end.
- sd_busy  in  1  controller busy.

Function
REQ-003 FSM states SHALL be IDLE, ISSUE, WAIT_BUSY, XFER, DONE, ERR.
REQ-004 IDLE: when req_valid && req_ready, the block SHALL latch req_write to sd_op_code and req_addr to sd_block_address, clear error and the 10-bit byte counter, then go to ISSUE.
REQ-005 ISSUE: sd_execute SHALL be held high until sd_busy is seen high, then the FSM SHALL go to WAIT_BUSY.
REQ-006 WAIT_BUSY SHALL go to XFER on the next cycle, with sd_execute low.
REQ-007 XFER read: each sd_finished_byte SHALL write sd_incoming_byte to buffer[count], then count+1; bytes with count >= 512 SHALL be dropped and SHALL set error.
REQ-008 XFER write: sd_outgoing_byte SHALL equal buffer[count] combinationally from the registered count; each sd_finished_byte SHALL advance count, saturating at 512 (last byte held).
REQ-009 In XFER, sd_finished_block SHALL go to DONE if count == 512, else to ERR.
REQ-010 If sd_finished_byte and sd_finished_block arrive in the same cycle, the byte SHALL be counted first; the count == 512 check uses the updated value.
REQ-011 DONE SHALL pulse done for exactly one cycle and return to IDLE.
REQ-012 ERR SHALL set error, pulse done for one cycle, and return to IDLE.
REQ-013 In states other than IDLE, buf_wr_en SHALL be ignored; buf_rd_data remains readable in all states.
REQ-014 Latency from the req accept edge to the first sd_execute high SHALL be 1 cycle.

Reset
REQ-015 On rst_n low, all outputs SHALL go immediately to: sd_execute=0, sd_op_code=0, sd_block_address=0, done=0, error=0, req_ready=0, sd_outgoing_byte=0, buf_rd_data=0; FSM=IDLE; count=0.
REQ-016 req_ready SHALL rise one cycle after rst_n deasserts.
REQ-017 Buffer contents SHALL NOT be cleared by reset.
REQ-018 Reset mid-transfer SHALL abort without a done pulse.

Configuration
REQ-019 Macro SD_BUF_TIMEOUT_EN SHALL control the transfer watchdog.
- Defined: a 24-bit counter runs in ISSUE, WAIT_BUSY and XFER; reaching TIMEOUT_CYCLES SHALL go to ERR.
- Undefined: no counter; the FSM waits indefinitely.

Structure
REQ-020 Shared package sd_pkg SHALL hold the FSM state typedef, BLOCK_BYTES=512, and op-code constants OP_READ/OP_WRITE.
REQ-021 Sub-module sd_buf_ram SHALL be a 512x8 simple dual-port RAM with a registered read port; port A is muxed between user writes and read-transfer writes.

Verification
REQ-022 The bench SHALL cover these directed scenarios:
- Read at addr 0x10: controller model sends 512 bytes of value i[7:0] then sd_finished_block -> done pulses once, error=0, buf_rd_data at index 300 = 0x2C.
- Write: preload buffer[i]=~i, issue write -> controller model samples sd_outgoing_byte 0xFF, 0xFE, ..., 512 bytes; done pulses once.
- sd_finished_block after 511 bytes -> error=1, done pulses once.
- 513 read bytes -> byte 513 dropped, error=1, buffer[0] unchanged.
- rst_n low at byte 200 of a read -> outputs zero, no done, req_ready=1 one cycle after release.
- With SD_BUF_TIMEOUT_EN and TIMEOUT_CYCLES=100, sd_busy stuck low -> ERR after 100 cycles, error=1.
